loop_replay_issuer: RTL and testbench

- Consumer end of the loop-buffer replay interface.
- Sits between fetch and decode.
- Passes fetched instructions through normally. While the loop-buffer controller holds block_signal, it issues replayed loop words instead, each tagged with a generated PC.
- Detects a not-taken loop-closing branch, returns a one-cycle mispredict pulse to the controller, and issues a fetch redirect.

---
 rtl/loop_replay_issuer.sv | 171 +++++++++++++++++
 tb/tb_loop_replay_issuer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_replay_issuer.sv
// Issues fetch words to decode, or replays loop-buffer words with generated PCs while block_signal is held.
// Outputs are registered, 1 cycle from inputs. Fetch is held via fetch_stall in PRIME/REPLAY. `REPLAY_STATS_EN adds replay_iterations.
module loop_replay_issuer #(
  parameter int MAX_LOOP_WORDS  = 27,
  parameter int RECOVER_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instruction,
  input  logic        block_signal,
  input  logic        flush,
  input  logic [31:0] loop_branch_pc,
  input  logic [31:0] loop_immediate,
  input  logic [31:0] replay_instruction,
  input  logic        branch_resolved,
  input  logic [31:0] branch_pc,
  input  logic        branch_taken,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instruction,
  output logic        squash,
  output logic        mispredict,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        fetch_stall,
`ifdef REPLAY_STATS_EN
  output logic [15:0] replay_iterations,
`endif
  output logic        timeout_err
);

  localparam int LW_W = $clog2(MAX_LOOP_WORDS + 1);
  localparam int TO_W = $clog2(RECOVER_TIMEOUT + 1);

  typedef enum logic [1:0] {S_PASS, S_PRIME, S_REPLAY, S_RECOVER} state_t;

  state_t            state, state_n;
  logic              block_q;
  logic [31:0]       start_pc, start_pc_n;
  logic [LW_W-1:0]   loop_words, loop_words_n;
  logic [LW_W-1:0]   idx, idx_n;
  logic [TO_W-1:0]   rec_cnt, rec_cnt_n, cnt_inc;
  logic [31:0]       words_full;
  logic              loop_ok, block_rise, mispred_hit, idx_last;

  logic              dec_valid_n, squash_n, mispredict_n, redirect_valid_n, fetch_stall_n, timeout_err_n;
  logic [31:0]       dec_pc_n, dec_instruction_n, redirect_pc_n;

  // Offset is a negative byte distance back to the loop head; word count includes the branch itself.
  assign words_full  = ((32'd0 - loop_immediate) >> 2) + 32'd1;
  assign loop_ok     = loop_immediate[31] && (words_full <= 32'(MAX_LOOP_WORDS));
  assign block_rise  = block_signal && !block_q;
  assign mispred_hit = branch_resolved && (branch_pc == loop_branch_pc) && !branch_taken;
  assign idx_last    = (idx == loop_words - 1'b1);
  assign cnt_inc     = rec_cnt + 1'b1;

  always_comb begin
    state_n           = state;
    start_pc_n        = start_pc;
    loop_words_n      = loop_words;
    idx_n             = idx;
    rec_cnt_n         = rec_cnt;
    dec_valid_n       = 1'b0;
    dec_pc_n          = dec_pc;
    dec_instruction_n = dec_instruction;
    squash_n          = 1'b0;
    mispredict_n      = 1'b0;
    redirect_valid_n  = 1'b0;
    redirect_pc_n     = redirect_pc;
    fetch_stall_n     = 1'b0;
    timeout_err_n     = timeout_err;
    unique case (state)
      S_PASS: begin
        dec_valid_n       = fetch_valid;
        dec_pc_n          = fetch_pc;
        dec_instruction_n = fetch_instruction;
        if (block_rise) begin
          start_pc_n   = loop_branch_pc + loop_immediate;
          loop_words_n = words_full[LW_W-1:0];
          if (loop_ok) state_n = S_PRIME;
        end
      end
      S_PRIME: begin
        fetch_stall_n = 1'b1;
        idx_n         = '0;
        state_n       = S_REPLAY;
      end
      S_REPLAY: begin
        if (mispred_hit) begin
          mispredict_n     = 1'b1;
          squash_n         = 1'b1;
          redirect_valid_n = 1'b1;
          redirect_pc_n    = loop_branch_pc + 32'd4;
          rec_cnt_n        = '0;
          state_n          = S_RECOVER;
        end else if (!block_signal) begin
          state_n = S_PASS;
        end else begin
          dec_valid_n       = 1'b1;
          dec_pc_n          = start_pc + 32'({idx, 2'b00});
          dec_instruction_n = replay_instruction;
          fetch_stall_n     = 1'b1;
          idx_n             = idx_last ? '0 : idx + 1'b1;
        end
      end
      S_RECOVER: begin
        if (flush) begin
          state_n = S_PASS;
        end else if (cnt_inc == TO_W'(RECOVER_TIMEOUT)) begin
          timeout_err_n = 1'b1;
          state_n       = S_PASS;
        end else begin
          rec_cnt_n = cnt_inc;
        end
      end
      default: state_n = S_PASS;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_PASS;
      block_q         <= 1'b0;
      start_pc        <= '0;
      loop_words      <= '0;
      idx             <= '0;
      rec_cnt         <= '0;
      dec_valid       <= 1'b0;
      dec_pc          <= '0;
      dec_instruction <= '0;
      squash          <= 1'b0;
      mispredict      <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
      fetch_stall     <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state           <= state_n;
      // Forgetting the level while recovering makes a held block_signal look like a fresh rise in PASS.
      block_q         <= (state == S_RECOVER) ? 1'b0 : block_signal;
      start_pc        <= start_pc_n;
      loop_words      <= loop_words_n;
      idx             <= idx_n;
      rec_cnt         <= rec_cnt_n;
      dec_valid       <= dec_valid_n;
      dec_pc          <= dec_pc_n;
      dec_instruction <= dec_instruction_n;
      squash          <= squash_n;
      mispredict      <= mispredict_n;
      redirect_valid  <= redirect_valid_n;
      redirect_pc     <= redirect_pc_n;
      fetch_stall     <= fetch_stall_n;
      timeout_err     <= timeout_err_n;
    end
  end

`ifdef REPLAY_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      replay_iterations <= '0;
    end else if (state == S_PASS && state_n == S_PRIME) begin
      replay_iterations <= '0;
    end else if (state == S_REPLAY && idx_last && replay_iterations != 16'hFFFF) begin
      replay_iterations <= replay_iterations + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_loop_replay_issuer.sv
// Table-driven bench for loop_replay_issuer with a queue scoreboard; hand sequences cover timeout, stats and async reset.
module tb_loop_replay_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_pc, fetch_instruction;
  logic        block_signal, flush;
  logic [31:0] loop_branch_pc, loop_immediate, replay_instruction;
  logic        branch_resolved;
  logic [31:0] branch_pc;
  logic        branch_taken;
  logic        dec_valid;
  logic [31:0] dec_pc, dec_instruction;
  logic        squash, mispredict, redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_stall, timeout_err;
`ifdef REPLAY_STATS_EN
  logic [15:0] replay_iterations;
`endif

  loop_replay_issuer dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instruction(fetch_instruction),
    .block_signal(block_signal), .flush(flush),
    .loop_branch_pc(loop_branch_pc), .loop_immediate(loop_immediate),
    .replay_instruction(replay_instruction),
    .branch_resolved(branch_resolved), .branch_pc(branch_pc), .branch_taken(branch_taken),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instruction(dec_instruction),
    .squash(squash), .mispredict(mispredict),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_stall(fetch_stall),
`ifdef REPLAY_STATS_EN
    .replay_iterations(replay_iterations),
`endif
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] fpc, finst;
    logic        blk, fl;
    logic [31:0] lbpc, limm, rinst;
    logic        br;
    logic [31:0] bpc;
    logic        bt;
    logic        e_dv;
    logic [31:0] e_pc, e_ins;
    logic        e_sq, e_mp, e_rv;
    logic [31:0] e_rpc;
    logic        e_st, e_to;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  logic sticky_to = 1'b0;
  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step%0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v.fv = 1'b0; v.fpc = '0; v.finst = '0; v.blk = 1'b0; v.fl = 1'b0;
    v.lbpc = 32'h120; v.limm = 32'hFFFF_FFF0; v.rinst = '0;
    v.br = 1'b0; v.bpc = '0; v.bt = 1'b0;
    v.e_dv = 1'b0; v.e_pc = '0; v.e_ins = '0; v.e_sq = 1'b0; v.e_mp = 1'b0;
    v.e_rv = 1'b0; v.e_rpc = '0; v.e_st = 1'b0; v.e_to = sticky_to;
    return v;
  endfunction

  function automatic vec_t fwd(input logic [31:0] pc, input logic [31:0] ins);
    vec_t v = idle();
    v.fv = 1'b1; v.fpc = pc; v.finst = ins;
    v.e_dv = 1'b1; v.e_pc = pc; v.e_ins = ins;
    return v;
  endfunction

  function automatic vec_t prime();
    vec_t v = idle();
    v.blk = 1'b1; v.e_st = 1'b1;
    return v;
  endfunction

  function automatic vec_t rep(input logic [31:0] ins, input logic [31:0] pc);
    vec_t v = idle();
    v.blk = 1'b1; v.rinst = ins;
    v.e_dv = 1'b1; v.e_pc = pc; v.e_ins = ins; v.e_st = 1'b1;
    return v;
  endfunction

  function automatic vec_t mispred(input logic blk);
    vec_t v = idle();
    v.blk = blk; v.br = 1'b1; v.bpc = 32'h120; v.bt = 1'b0;
    v.e_sq = 1'b1; v.e_mp = 1'b1; v.e_rv = 1'b1; v.e_rpc = 32'h124;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    fetch_valid = v.fv; fetch_pc = v.fpc; fetch_instruction = v.finst;
    block_signal = v.blk; flush = v.fl;
    loop_branch_pc = v.lbpc; loop_immediate = v.limm; replay_instruction = v.rinst;
    branch_resolved = v.br; branch_pc = v.bpc; branch_taken = v.bt;
  endtask

  // Called at a negedge; drives one cycle, lets the posedge capture, compares at the next negedge.
  task automatic apply(input vec_t v, input int id);
    vec_t e;
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("dec_valid", id, 32'(dec_valid), 32'(e.e_dv));
    if (e.e_dv) begin
      chk("dec_pc", id, dec_pc, e.e_pc);
      chk("dec_instruction", id, dec_instruction, e.e_ins);
    end
    chk("squash", id, 32'(squash), 32'(e.e_sq));
    chk("mispredict", id, 32'(mispredict), 32'(e.e_mp));
    chk("redirect_valid", id, 32'(redirect_valid), 32'(e.e_rv));
    if (e.e_rv) chk("redirect_pc", id, redirect_pc, e.e_rpc);
    chk("fetch_stall", id, 32'(fetch_stall), 32'(e.e_st));
    chk("timeout_err", id, 32'(timeout_err), 32'(e.e_to));
  endtask

  task automatic check_zero(input int id);
    chk("rst_dec_valid", id, 32'(dec_valid), 32'd0);
    chk("rst_dec_pc", id, dec_pc, 32'd0);
    chk("rst_dec_instruction", id, dec_instruction, 32'd0);
    chk("rst_squash", id, 32'(squash), 32'd0);
    chk("rst_mispredict", id, 32'(mispredict), 32'd0);
    chk("rst_redirect_valid", id, 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", id, redirect_pc, 32'd0);
    chk("rst_fetch_stall", id, 32'(fetch_stall), 32'd0);
    chk("rst_timeout_err", id, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   id;

    // Passthrough and ignored-event patterns.
    tbl.push_back(fwd(32'h100, 32'h0000_0013));
    v = idle(); v.fpc = 32'h104; v.finst = 32'hDEAD_BEEF; tbl.push_back(v);
    tbl.push_back(fwd(32'h200, 32'hFFFF_FFFF));
    v = fwd(32'h300, 32'h33); v.fl = 1'b1; tbl.push_back(v);
    v = fwd(32'h304, 32'h34); v.br = 1'b1; v.bpc = 32'h120; tbl.push_back(v);
    // Oversize loop (33 words) and positive offset never leave PASS.
    v = fwd(32'h400, 32'h40); v.blk = 1'b1; v.limm = 32'hFFFF_FF80; tbl.push_back(v);
    v = fwd(32'h404, 32'h41); v.blk = 1'b1; v.limm = 32'hFFFF_FF80; tbl.push_back(v);
    tbl.push_back(fwd(32'h408, 32'h42));
    v = fwd(32'h500, 32'h50); v.blk = 1'b1; v.limm = 32'h10; tbl.push_back(v);
    tbl.push_back(fwd(32'h504, 32'h51));
    // Replay entry: fetch word in the rise cycle passes, then one bubble, then the 5-word loop wraps.
    v = fwd(32'h600, 32'h60); v.blk = 1'b1; tbl.push_back(v);
    tbl.push_back(prime());
    for (int k = 0; k < 7; k++) begin
      v = rep(32'h1000 + k, 32'h110 + 4 * (k % 5));
      if (k == 3) begin v.br = 1'b1; v.bpc = 32'h120; v.bt = 1'b1; end
      if (k == 5) begin v.br = 1'b1; v.bpc = 32'h11C; v.bt = 1'b0; end
      tbl.push_back(v);
    end
    tbl.push_back(mispred(1'b1));
    tbl.push_back(idle());
    v = idle(); v.fl = 1'b1; tbl.push_back(v);
    tbl.push_back(fwd(32'h124, 32'h77));
    // block_signal falls without a mispredict.
    v = idle(); v.blk = 1'b1; tbl.push_back(v);
    tbl.push_back(prime());
    tbl.push_back(rep(32'h2000, 32'h110));
    tbl.push_back(idle());
    tbl.push_back(fwd(32'h704, 32'h70));
    // Mispredict and fall together; rise during RECOVER is taken up once back in PASS.
    v = idle(); v.blk = 1'b1; tbl.push_back(v);
    tbl.push_back(prime());
    tbl.push_back(rep(32'h3000, 32'h110));
    tbl.push_back(mispred(1'b0));
    v = idle(); v.blk = 1'b1; v.fl = 1'b1; tbl.push_back(v);
    v = fwd(32'h800, 32'h80); v.blk = 1'b1; tbl.push_back(v);
    tbl.push_back(prime());
    tbl.push_back(rep(32'h4000, 32'h110));
    tbl.push_back(idle());

    reset = 1'b1;
    drive(idle());
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero(0);
    reset = 1'b0;

    id = 1;
    foreach (tbl[i]) begin
      apply(tbl[i], id);
      id++;
    end

    // Mispredict with no flush: timeout after 8 RECOVER cycles, sticky afterwards.
    v = idle(); v.blk = 1'b1; apply(v, id++);
    apply(prime(), id++);
    apply(rep(32'h5000, 32'h110), id++);
    apply(mispred(1'b1), id++);
    for (int i = 0; i < 8; i++) begin
      v = idle();
      if (i == 7) v.e_to = 1'b1;
      apply(v, id++);
    end
    sticky_to = 1'b1;
    apply(fwd(32'h900, 32'h90), id++);

`ifdef REPLAY_STATS_EN
    v = idle(); v.blk = 1'b1; apply(v, id++);
    apply(prime(), id++);
    for (int k = 0; k < 15; k++) apply(rep(32'h6000 + k, 32'h110 + 4 * (k % 5)), id++);
    apply(idle(), id++);
    chk("replay_iterations", id, 32'(replay_iterations), 32'd3);
    v = idle(); v.blk = 1'b1; apply(v, id++);
    chk("replay_iterations_clr", id, 32'(replay_iterations), 32'd0);
    apply(prime(), id++);
    apply(idle(), id++);
`endif

    // Reset asserted mid-REPLAY clears outputs without waiting for a clock edge.
    v = idle(); v.blk = 1'b1; apply(v, id++);
    apply(prime(), id++);
    apply(rep(32'h7000, 32'h110), id++);
    apply(rep(32'h7001, 32'h114), id++);
    reset = 1'b1;
    #1;
    check_zero(id++);
    sticky_to = 1'b0;
    drive(idle());
    @(negedge clk);
    reset = 1'b0;
    apply(fwd(32'hA00, 32'hA0), id++);
    apply(fwd(32'hA04, 32'hA4), id++);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
